// File: rtl/deserializer_frame.sv
// deserializer_frame: packs BIT_WIDTH-bit samples into frames of cfg_len words; DESER_RECV_LAST_EN adds early close via recv_last.
// Latency: last sample accepted at edge t -> send_val high after edge t+1 when the output bank is free.
// Backpressure: double-buffered; recv_rdy drops only while both banks hold frames and rises combinationally with send_rdy.
module deserializer_frame #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32,
  parameter int LEN_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LEN_W-1:0]               cfg_len,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
`ifdef DESER_RECV_LAST_EN
  input  logic                           recv_last,
`endif
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg,
  output logic [LEN_W-1:0]               send_len
);
  typedef logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] bank_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(N_SAMPLES);

  logic [LEN_W-1:0] count, len_q, cfg_eff, cur_len;
  logic             fill_full;
  bank_t            fill_bank, out_bank, out_masked;
  logic             recv_fire, xfer, last_word, close, recv_last_i;

`ifdef DESER_RECV_LAST_EN
  assign recv_last_i = recv_last;
`else
  assign recv_last_i = 1'b0;
`endif

  // Length is taken from cfg_len only while writing word 0; afterwards the latched value rules.
  assign cfg_eff   = (cfg_len == '0 || cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign cur_len   = (count == '0) ? cfg_eff : len_q;
  assign last_word = (count == cur_len - LEN_W'(1));
  assign close     = last_word || recv_last_i;

  assign xfer      = fill_full && (!send_val || send_rdy);
  assign recv_rdy  = reset && (!fill_full || xfer);
  assign recv_fire = recv_val && recv_rdy;

  always_comb begin
    out_masked = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (LEN_W'(i) < len_q) out_masked[i] = fill_bank[i];
    end
  end

  // A recv on the xfer cycle overrides the bank clear for word 0 (later NBA wins).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      len_q     <= '0;
      fill_full <= 1'b0;
      fill_bank <= '0;
    end else begin
      if (xfer) begin
        fill_full <= 1'b0;
        fill_bank <= '0;
      end
      if (recv_fire) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
          if (count == LEN_W'(i)) fill_bank[i] <= recv_msg;
        end
        if (count == '0) len_q <= cfg_eff;
        if (close) begin
          count     <= '0;
          fill_full <= 1'b1;
          len_q     <= count + LEN_W'(1);
        end else begin
          count <= count + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_val <= 1'b0;
      out_bank <= '0;
      send_len <= '0;
    end else if (xfer) begin
      send_val <= 1'b1;
      out_bank <= out_masked;
      send_len <= len_q;
    end else if (send_val && send_rdy) begin
      send_val <= 1'b0;
    end
  end

  assign send_msg = out_bank;

endmodule

// File: tb/tb_deserializer_frame.sv
// Randomised and directed bench for deserializer_frame against a frame-level queue model.
module tb_deserializer_frame;
  localparam int N  = 8;
  localparam int BW = 32;
  localparam int LW = $clog2(N + 1);
  localparam int MW = N * BW;
`ifdef DESER_RECV_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] cfg_len;
  logic          recv_val, recv_rdy;
  logic [BW-1:0] recv_msg;
  logic          send_val, send_rdy;
  logic [MW-1:0] send_msg;
  logic [LW-1:0] send_len;
`ifdef DESER_RECV_LAST_EN
  logic          recv_last;
`endif

  deserializer_frame #(.N_SAMPLES(N), .BIT_WIDTH(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_len  (cfg_len),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
`ifdef DESER_RECV_LAST_EN
    .recv_last(recv_last),
`endif
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .send_len (send_len)
  );

  always #5 clk = ~clk;

  int passed;
  int total;
  int frames_seen;

  // Model: one frame presented downstream, one complete frame waiting, one partial frame.
  logic [MW-1:0] m_out_msg, m_full_msg;
  logic [LW-1:0] m_out_len, m_full_len;
  bit            m_out_v, m_full_v;
  logic [BW-1:0] part[$];
  int            part_len;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic int clamp(input int c);
    return (c == 0 || c > N) ? N : c;
  endfunction

  function automatic bit model_rdy(input bit sr);
    return !m_full_v || !m_out_v || sr;
  endfunction

  function automatic logic [MW-1:0] seq_frame(input int first, input int n);
    logic [MW-1:0] f;
    f = '0;
    for (int i = 0; i < n; i++) f[i*BW +: BW] = BW'(first + i);
    return f;
  endfunction

  task automatic model_reset();
    m_out_msg = '0; m_out_len = '0; m_out_v = 1'b0;
    m_full_msg = '0; m_full_len = '0; m_full_v = 1'b0;
    part.delete();
    part_len = 0;
  endtask

  task automatic model_step(input bit rv, input logic [BW-1:0] msg, input bit last, input int cfg, input bit sr);
    bit fire;
    fire = rv && model_rdy(sr);
    if (m_full_v && (!m_out_v || sr)) begin
      m_out_msg = m_full_msg;
      m_out_len = m_full_len;
      m_out_v   = 1'b1;
      m_full_v  = 1'b0;
    end else if (m_out_v && sr) begin
      m_out_v = 1'b0;
    end
    if (fire) begin
      if (part.size() == 0) part_len = clamp(cfg);
      part.push_back(msg);
      if (part.size() == part_len || (LAST_EN && last)) begin
        m_full_msg = '0;
        foreach (part[i]) m_full_msg[i*BW +: BW] = part[i];
        m_full_len = LW'(part.size());
        m_full_v   = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic compare_outputs();
    chk("recv_rdy", recv_rdy, model_rdy(send_rdy));
    chk("send_val", send_val, m_out_v);
    chk("send_msg", send_msg, m_out_msg);
    chk("send_len", send_len, m_out_len);
    if (send_val && send_rdy) frames_seen++;
  endtask

  // Called just after a falling edge; leaves time just after the next falling edge.
  task automatic cycle(input bit rv, input logic [BW-1:0] msg, input bit last, input int cfg, input bit sr);
    recv_val = rv;
    recv_msg = msg;
    cfg_len  = LW'(cfg);
    send_rdy = sr;
`ifdef DESER_RECV_LAST_EN
    recv_last = last;
`endif
    #1;
    compare_outputs();
    model_step(rv, msg, last, cfg, sr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int v;
    passed = 0; total = 0; frames_seen = 0;
    reset = 1'b0; recv_val = 1'b0; recv_msg = '0; cfg_len = '0; send_rdy = 1'b0;
`ifdef DESER_RECV_LAST_EN
    recv_last = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdy", recv_rdy, 0);
    chk("reset_val", send_val, 0);
    chk("reset_msg", send_msg, 0);
    chk("reset_len", send_len, 0);
    reset = 1'b1;
    #1;
    chk("release_rdy", recv_rdy, 1);

    // Fixed length 4, send_rdy high.
    cycle(1, 32'h11, 0, 4, 1);
    cycle(1, 32'h22, 0, 4, 1);
    cycle(1, 32'h33, 0, 4, 1);
    cycle(1, 32'h44, 0, 4, 1);
    chk("t1_val_not_yet", send_val, 0);
    cycle(0, 0, 0, 4, 1);
    chk("t1_val", send_val, 1);
    chk("t1_msg", send_msg, {128'h0, 32'h44, 32'h33, 32'h22, 32'h11});
    chk("t1_len", send_len, 4);
    repeat (2) cycle(0, 0, 0, 4, 1);

    // Backpressure: two frames buffered, then drained in order.
    v = 1;
    for (int k = 0; k < 40 && v <= 16; k++) begin
      bit f;
      f = model_rdy(1'b0);
      cycle(1, BW'(v), 0, 8, 0);
      if (f) v++;
    end
    chk("bp_all_accepted", v, 17);
    cycle(0, 0, 0, 8, 0);
    chk("bp_rdy_low", recv_rdy, 0);
    chk("bp_frame1", send_msg, seq_frame(1, 8));
    send_rdy = 1'b1;
    #1;
    chk("bp_rdy_xfer", recv_rdy, 1);
    cycle(0, 0, 0, 8, 1);
    chk("bp_frame2", send_msg, seq_frame(9, 8));
    chk("bp_frame2_val", send_val, 1);
    repeat (3) cycle(0, 0, 0, 8, 1);

    // Full throughput at length 2.
    frames_seen = 0;
    for (int i = 0; i < 20; i++) begin
      send_rdy = 1'b1;
      #1;
      chk("thru_rdy", recv_rdy, 1);
      cycle(1, BW'(i), 0, 2, 1);
    end
    repeat (3) cycle(0, 0, 0, 2, 1);
    chk("thru_frames", frames_seen, 10);
    chk("thru_last_msg", send_msg, {192'h0, 32'd19, 32'd18});
    chk("thru_last_len", send_len, 2);

    // Length clamp and latch.
    for (int i = 0; i < 8; i++) cycle(1, BW'(100 + i), 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    chk("clamp_zero_len", send_len, 8);
    for (int i = 0; i < 8; i++) cycle(1, BW'(200 + i), 0, 12, 1);
    repeat (3) cycle(0, 0, 0, 12, 1);
    chk("clamp_big_len", send_len, 8);
    cycle(1, 32'h31, 0, 3, 1);
    cycle(1, 32'h32, 0, 5, 1);
    cycle(1, 32'h33, 0, 5, 1);
    repeat (3) cycle(0, 0, 0, 5, 1);
    chk("latch_len", send_len, 3);
    chk("latch_msg", send_msg, {160'h0, 32'h33, 32'h32, 32'h31});

    // Asynchronous reset mid-frame with a frame pending downstream.
    for (int i = 0; i < 13; i++) cycle(1, BW'(300 + i), 0, 8, 0);
    chk("pre_reset_val", send_val, 1);
    recv_val = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_val", send_val, 0);
    chk("arst_msg", send_msg, 0);
    chk("arst_rdy", recv_rdy, 0);
    chk("arst_len", send_len, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1, BW'(32'hA0 + i), 0, 8, 1);
    repeat (3) cycle(0, 0, 0, 8, 1);
    chk("post_reset_msg", send_msg, seq_frame(32'hA0, 8));
    chk("post_reset_len", send_len, 8);

`ifdef DESER_RECV_LAST_EN
    cycle(1, 32'hA, 0, 8, 1);
    cycle(1, 32'hB, 0, 8, 1);
    cycle(1, 32'hC, 1, 8, 1);
    repeat (3) cycle(0, 0, 0, 8, 1);
    chk("last_len", send_len, 3);
    chk("last_msg", send_msg, {160'h0, 32'hC, 32'hB, 32'hA});
    cycle(1, 32'hD, 1, 8, 1);
    repeat (3) cycle(0, 0, 0, 8, 1);
    chk("last_w0_len", send_len, 1);
`endif

    // Randomised traffic, alternating light and heavy backpressure.
    for (int i = 0; i < 800; i++) begin
      bit sr;
      sr = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15), sr);
    end
    repeat (4) cycle(0, 0, 0, 8, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/deserializer_frame.md
Name: deserializer_frame

Overview:
- Next-generation parametrised deserializer: collects BIT_WIDTH-bit samples over a val/rdy stream into a frame of up to N_SAMPLES words.
- Frame length is selected at runtime rather than fixed.
- Double-buffered (fill bank + output bank), so a new frame fills while the previous one waits on the downstream consumer; sustains one sample per cycle.
- Sits between the serial sample source (SPI/ADC front end) and parallel consumers such as the FFT/classifier blocks.

Parameters:
- N_SAMPLES, 8, maximum words per frame (>=2).
- BIT_WIDTH, 32, bits per sample.
- LEN_W, $clog2(N_SAMPLES+1), width of the length fields (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_len  input  LEN_W  requested frame length.
- recv_val  input  1  input sample valid.
- recv_rdy  output  1  block can accept a sample.
- recv_msg  input  BIT_WIDTH  input sample.
- send_val  output  1  output frame valid.
- send_rdy  input  1  consumer accepts the frame.
- send_msg  output  N_SAMPLES*BIT_WIDTH  frame, flattened; word i at bits [i*BIT_WIDTH +: BIT_WIDTH]; word 0 = first sample received.
- send_len  output  LEN_W  number of valid words in send_msg.

Behaviour:
- Reset:
  - While reset=0, all state clears asynchronously: fill count, fill_full, latched length, both banks, send_val=0, send_msg=0, send_len=0.
  - recv_rdy is forced to 0 while reset=0.
  - recv_rdy goes to 1 in the first cycle after release.
- Transfers: a recv transfer occurs on a cycle with recv_val && recv_rdy; a send transfer occurs on a cycle with send_val && send_rdy.
- Length latch:
  - cfg_len is sampled on the recv transfer that writes word 0 and held in len_q for the rest of the frame.
  - cfg_len changes mid-frame are ignored.
  - cfg_len==0 or cfg_len>N_SAMPLES is treated as N_SAMPLES.
- Fill bank state:
  - count (0..N_SAMPLES-1) and fill_full.
  - Each recv transfer writes recv_msg into fill word[count], then count increments.
  - When the written word is word len_q-1: count returns to 0 and fill_full is set on the next edge.
- Bank transfer:
  - xfer = fill_full && (!send_val || send_rdy).
  - On xfer: the output bank takes the fill bank, with words at index >= len_q forced to 0; send_len<=len_q; send_val<=1; fill_full<=0; fill bank cleared.
  - Otherwise, on a send transfer: send_val<=0. send_msg and send_len hold their last values.
- recv_rdy = !fill_full || xfer.
  - This is a combinational path from send_rdy to recv_rdy and is intentional.
  - On a cycle where xfer and a recv transfer coincide, the new sample lands in fill word 0 and the rest of the fill bank clears; the copy uses the pre-edge contents.
- Latency and throughput:
  - Last sample accepted at edge t: fill_full is high after t; send_val is high after t+1 if the output bank is free.
  - With send_rdy held at 1, recv_rdy stays 1 continuously (no bubbles).
- Backpressure:
  - Output bank occupied and fill bank full: recv_rdy=0 until send_rdy.
  - At most two frames are buffered; no sample is ever dropped or overwritten.
- send_msg/send_len are stable while send_val=1 && !send_rdy.
- len_q==1: every accepted sample forms a frame.
- Reset asserted mid-frame discards all partial and pending frames.

Optional Feature:
- Macro DESER_RECV_LAST_EN.
- When defined:
  - Adds input port recv_last (1 bit).
  - A recv transfer with recv_last=1 closes the frame early: len_q <= count+1, fill_full is set, and the remaining words are zero on output.
  - recv_last on the word that already reaches len_q has no extra effect.
  - recv_last on word 0 yields send_len=1.
- When undefined: no recv_last port; frames close only on reaching len_q.

Test Plan:
- Fixed length: cfg_len=4, send_rdy=1, recv 0x11,0x22,0x33,0x44 back-to-back.
  - send_val pulses 2 cycles after 0x44 is accepted.
  - send_msg words 0..3 = 0x11..0x44, words 4..7 = 0, send_len=4.
- Backpressure: cfg_len=8, send_rdy=0, stream 16 samples 1..16.
  - First frame (1..8) held on send_msg; second frame fills; recv_rdy=0 from cycle after sample 16 accepted.
  - Raise send_rdy: frames 1..8 then 9..16 delivered in order; recv_rdy returns to 1 in the same cycle as xfer.
- Full throughput: cfg_len=2, send_rdy=1, recv_val=1 for 20 cycles with values 0..19.
  - recv_rdy never drops; 10 frames {0,1},{2,3},...,{18,19} with send_len=2.
- Clamp/latch: cfg_len=0 gives send_len=8; cfg_len=12 gives send_len=8; cfg_len changed 3->5 after word 0 gives send_len=3.
- Async reset: assert reset=0 mid-frame (count=5) and with a pending frame, between clock edges.
  - send_val, send_msg and recv_rdy go to 0 immediately.
  - After release, the next 8 samples form a clean frame.
- DESER_RECV_LAST_EN: cfg_len=8, recv 0xA,0xB,0xC with recv_last on 0xC.
  - send_len=3, words 0..2 = 0xA,0xB,0xC, words 3..7 = 0.
